ladybug_rom_loader: RTL and testbench

// Sits between data_io and the Lady Bug ROM/PROM dprams. Registers the ioctl download stream,

---
 rtl/ladybug_rom_pkg.sv | 49 ++++
 rtl/ladybug_rom_decode.sv | 45 ++++
 rtl/ladybug_rom_loader.sv | 160 ++++++++++++++++
 tb/tb_ladybug_rom_loader.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ladybug_rom_pkg.sv
// Shared types and constants for the Lady Bug ROM download loader.
package ladybug_rom_pkg;

  localparam int REGION_NUM = 11;

  // Destination regions, in write-enable bit order.
  typedef enum logic [3:0] {
    RG_CPU0,
    RG_CPU1,
    RG_CPU2,
    RG_SPR_L,
    RG_SPR_H,
    RG_CHR_L,
    RG_CHR_H,
    RG_LU,
    RG_RGB,
    RG_CTRL_LU,
    RG_DECRYPT
  } region_e;

  // Byte count that makes each region complete.
  localparam int REGION_SIZE [REGION_NUM] = '{
    8192, 8192, 8192, 4096, 4096, 4096, 4096, 32, 32, 32, 256
  };

  // Width of the region-relative address for each region.
  localparam int REGION_AW [REGION_NUM] = '{
    13, 13, 13, 12, 12, 12, 12, 5, 5, 5, 8
  };

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CHECK,
    HOLD,
    RUN
  } state_e;

  // One-hot write-enable pattern for a region.
  function automatic logic [REGION_NUM-1:0] region_bit(region_e r);
    return REGION_NUM'(1) << r;
  endfunction

  // Mask keeping only the offset bits a region actually uses.
  function automatic logic [12:0] offset_mask(region_e r);
    return 13'((32'd1 << REGION_AW[r]) - 32'd1);
  endfunction

endpackage

// File: rtl/ladybug_rom_decode.sv
// Combinational decode of a download byte address into its ROM region.
module ladybug_rom_decode
  import ladybug_rom_pkg::*;
(
  input  logic [24:0]           addr,
  output logic [REGION_NUM-1:0] region_oh,
  output logic [12:0]           offset,
  output logic                  in_map
);

  logic [11:0] bank;
  region_e     region;

  assign bank = addr[24:13];

  // Pick the region from the 8K bank and sub-fields; anything unlisted is out of map.
  always_comb begin
    region = RG_CPU0;
    in_map = 1'b1;
    case (bank)
      12'd0: region = RG_CPU0;
      12'd1: region = RG_CPU1;
      12'd2: region = RG_CPU2;
      12'd3: region = addr[12] ? RG_SPR_H : RG_SPR_L;
      12'd4: region = addr[12] ? RG_CHR_H : RG_CHR_L;
      12'd5: begin
        if (addr[12:5] == 8'd0) begin
          region = RG_LU;
        end else if (addr[12:5] == 8'd1) begin
          region = RG_RGB;
        end else if (addr[12:5] == 8'd2) begin
          region = RG_CTRL_LU;
        end else if (addr[12:8] == 5'd1) begin
          region = RG_DECRYPT;
        end else begin
          in_map = 1'b0;
        end
      end
      default: in_map = 1'b0;
    endcase
    region_oh = in_map ? region_bit(region) : '0;
    offset    = in_map ? (addr[12:0] & offset_mask(region)) : '0;
  end

endmodule

// File: rtl/ladybug_rom_loader.sv
// Routes the data_io ROM download into the Lady Bug ROM/PROM dprams, verifies
// that every region was filled and keeps the machine in reset until it was.
module ladybug_rom_loader
  import ladybug_rom_pkg::*;
#(
  parameter logic [7:0] ROM_INDEX   = 8'd0,
  parameter int         HOLD_CYCLES = 16
) (
  input  logic                  clk_i,
  input  logic                  res_n_i,
  input  logic                  ioctl_download_i,
  input  logic [7:0]            ioctl_index_i,
  input  logic                  ioctl_wr_i,
  input  logic [24:0]           ioctl_addr_i,
  input  logic [7:0]            ioctl_dout_i,
  output logic [12:0]           wr_addr_o,
  output logic [7:0]            wr_data_o,
  output logic [REGION_NUM-1:0] we_o,
  output logic                  load_done_o,
  output logic                  load_err_o,
  output logic [15:0]           checksum_o,
  output logic                  core_reset_n_o
);

  localparam logic [15:0] HOLD_LAST = 16'(HOLD_CYCLES - 1);

  state_e                state;
  logic                  download_q;
  logic [15:0]           hold_cnt;
  logic [13:0]           cnt [REGION_NUM];
  logic                  all_full;
  logic                  index_match;
  logic                  start;
  logic                  enter_load;
  logic                  accept;
  logic [REGION_NUM-1:0] dec_oh;
  logic [12:0]           dec_offset;
  logic                  dec_in_map;

  ladybug_rom_decode u_decode (
    .addr      (ioctl_addr_i),
    .region_oh (dec_oh),
    .offset    (dec_offset),
    .in_map    (dec_in_map)
  );

  assign index_match = (ioctl_index_i == ROM_INDEX);
  assign start       = ioctl_download_i & ~download_q & index_match;
  assign enter_load  = start & ((state == IDLE) | (state == RUN));
  assign accept      = ioctl_wr_i & ioctl_download_i & index_match & (state == LOAD);

  // Remember the previous download level to find its edges.
  always_ff @(posedge clk_i or negedge res_n_i) begin
    if (!res_n_i) begin
      download_q <= 1'b0;
    end else begin
      download_q <= ioctl_download_i;
    end
  end

  // Register the decoded write so the dpram sees a clean one-cycle strobe.
  always_ff @(posedge clk_i or negedge res_n_i) begin
    if (!res_n_i) begin
      we_o      <= '0;
      wr_addr_o <= '0;
      wr_data_o <= '0;
    end else begin
      we_o <= (accept & dec_in_map) ? dec_oh : '0;
      if (accept & dec_in_map) begin
        wr_addr_o <= dec_offset;
        wr_data_o <= ioctl_dout_i;
      end
    end
  end

  // Per-region byte counters, saturating at the region size.
  always_ff @(posedge clk_i or negedge res_n_i) begin
    if (!res_n_i) begin
      for (int i = 0; i < REGION_NUM; i++) cnt[i] <= '0;
    end else if (enter_load) begin
      for (int i = 0; i < REGION_NUM; i++) cnt[i] <= '0;
    end else if (accept) begin
      for (int i = 0; i < REGION_NUM; i++) begin
        if (dec_oh[i] && (cnt[i] != 14'(REGION_SIZE[i]))) cnt[i] <= cnt[i] + 14'd1;
      end
    end
  end

  // A load is complete only when every region reached its size.
  always_comb begin
    all_full = 1'b1;
    for (int i = 0; i < REGION_NUM; i++) begin
      if (cnt[i] != 14'(REGION_SIZE[i])) all_full = 1'b0;
    end
  end

  // Running sum of every in-map byte of the current download.
  always_ff @(posedge clk_i or negedge res_n_i) begin
    if (!res_n_i) begin
      checksum_o <= '0;
    end else if (enter_load) begin
      checksum_o <= '0;
    end else if (accept & dec_in_map) begin
      checksum_o <= checksum_o + {8'h00, ioctl_dout_i};
    end
  end

  // Load sequencing: collect, verify, hold the machine in reset, then release it.
  always_ff @(posedge clk_i or negedge res_n_i) begin
    if (!res_n_i) begin
      state          <= IDLE;
      hold_cnt       <= '0;
      load_done_o    <= 1'b0;
      load_err_o     <= 1'b0;
      core_reset_n_o <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (enter_load) begin
            state       <= LOAD;
            load_done_o <= 1'b0;
            load_err_o  <= 1'b0;
          end
        end
        LOAD: begin
          if (accept && !dec_in_map) load_err_o <= 1'b1;
          if (!ioctl_download_i) state <= CHECK;
        end
        CHECK: begin
          if (all_full && !load_err_o) begin
            load_done_o <= 1'b1;
            hold_cnt    <= '0;
            state       <= HOLD;
          end else begin
            load_err_o <= 1'b1;
            state      <= IDLE;
          end
        end
        HOLD: begin
          if (hold_cnt == HOLD_LAST) begin
            core_reset_n_o <= 1'b1;
            state          <= RUN;
          end else begin
            hold_cnt <= hold_cnt + 16'd1;
          end
        end
        RUN: begin
          if (enter_load) begin
            core_reset_n_o <= 1'b0;
            load_done_o    <= 1'b0;
            load_err_o     <= 1'b0;
            state          <= LOAD;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ladybug_rom_loader.sv
// Self-checking bench for ladybug_rom_loader against an event-level reference model.
module tb_ladybug_rom_loader;

  localparam int HOLD = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        dl = 1'b0;
  logic [7:0]  idx = 8'd0;
  logic        wr = 1'b0;
  logic [24:0] addr = '0;
  logic [7:0]  dout = '0;
  logic [12:0] wr_addr;
  logic [7:0]  wr_data;
  logic [10:0] we;
  logic        done;
  logic        err;
  logic [15:0] checksum;
  logic        core_rstn;

  int n_vec = 0;
  int n_err = 0;
  bit check_en = 1'b0;

  ladybug_rom_loader #(
    .ROM_INDEX   (8'd0),
    .HOLD_CYCLES (HOLD)
  ) dut (
    .clk_i            (clk),
    .res_n_i          (rst_n),
    .ioctl_download_i (dl),
    .ioctl_index_i    (idx),
    .ioctl_wr_i       (wr),
    .ioctl_addr_i     (addr),
    .ioctl_dout_i     (dout),
    .wr_addr_o        (wr_addr),
    .wr_data_o        (wr_data),
    .we_o             (we),
    .load_done_o      (done),
    .load_err_o       (err),
    .checksum_o       (checksum),
    .core_reset_n_o   (core_rstn)
  );

  always #5 clk = ~clk;

  // Region sizes and address map expressed as plain address ranges.
  int SIZE [11] = '{8192, 8192, 8192, 4096, 4096, 4096, 4096, 32, 32, 32, 256};

  function automatic void model_decode(input int a, output int r, output int off, output bit inmap);
    inmap = 1'b1;
    r = 0;
    off = 0;
    if (a < 'h6000) begin
      r = a / 8192;
      off = a % 8192;
    end else if (a < 'hA000) begin
      r = 3 + (a - 'h6000) / 4096;
      off = a % 4096;
    end else if (a < 'hA060) begin
      r = 7 + (a - 'hA000) / 32;
      off = a % 32;
    end else if (a >= 'hA100 && a < 'hA200) begin
      r = 10;
      off = a % 256;
    end else begin
      inmap = 1'b0;
    end
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state: what the outputs must be after each clock edge.
  int          cnt [11];
  logic [15:0] m_sum = '0;
  bit          m_err = 1'b0;
  bit          m_done = 1'b0;
  bit          m_run = 1'b0;
  bit          m_loading = 1'b0;
  logic [10:0] m_we = '0;
  logic [12:0] m_addr = '0;
  logic [7:0]  m_data = '0;
  bit          prev_dl = 1'b0;
  int          cyc = 0;
  int          verdict_at = -1;
  int          run_at = -1;
  bit          mb_acc, mb_start, mb_fall, mb_busy, mb_inmap, mb_full;
  int          mb_r, mb_off;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 11; i++) cnt[i] = 0;
      m_sum = '0; m_err = 1'b0; m_done = 1'b0; m_run = 1'b0; m_loading = 1'b0;
      m_we = '0; m_addr = '0; m_data = '0; prev_dl = 1'b0;
      cyc = 0; verdict_at = -1; run_at = -1;
    end else begin
      cyc++;
      mb_busy  = m_loading || (verdict_at >= 0) || (run_at >= 0);
      mb_start = !mb_busy && dl && !prev_dl && (idx == 8'd0);
      mb_acc   = m_loading && dl && wr && (idx == 8'd0);
      mb_fall  = m_loading && !dl;
      m_we = '0;
      if (mb_acc) begin
        model_decode(int'(addr), mb_r, mb_off, mb_inmap);
        if (mb_inmap) begin
          m_we = 11'(1) << mb_r;
          m_addr = 13'(mb_off);
          m_data = dout;
          if (cnt[mb_r] < SIZE[mb_r]) cnt[mb_r]++;
          m_sum = m_sum + 16'(dout);
        end else begin
          m_err = 1'b1;
        end
      end
      if (verdict_at == cyc) begin
        verdict_at = -1;
        mb_full = 1'b1;
        for (int i = 0; i < 11; i++) if (cnt[i] != SIZE[i]) mb_full = 1'b0;
        if (mb_full && !m_err) begin
          m_done = 1'b1;
          run_at = cyc + HOLD;
        end else begin
          m_err = 1'b1;
        end
      end
      if (run_at == cyc) begin
        run_at = -1;
        m_run = 1'b1;
      end
      if (mb_fall) begin
        m_loading = 1'b0;
        verdict_at = cyc + 1;
      end
      if (mb_start) begin
        m_loading = 1'b1;
        for (int i = 0; i < 11; i++) cnt[i] = 0;
        m_sum = '0; m_done = 1'b0; m_err = 1'b0; m_run = 1'b0;
      end
      prev_dl = dl;
    end
  end

  // Compare every output against the model each cycle, away from the clock edge.
  always @(negedge clk) begin
    if (check_en) begin
      checkOutput("we", 32'(we), 32'(m_we));
      checkOutput("done", 32'(done), 32'(m_done));
      checkOutput("err", 32'(err), 32'(m_err));
      checkOutput("checksum", 32'(checksum), 32'(m_sum));
      checkOutput("core_rstn", 32'(core_rstn), 32'(m_run));
      if (m_we != '0) begin
        checkOutput("wr_addr", 32'(wr_addr), 32'(m_addr));
        checkOutput("wr_data", 32'(wr_data), 32'(m_data));
      end
    end
  end

  task automatic applyStimulus(input bit d, input logic [7:0] i, input bit w,
                               input logic [24:0] a, input logic [7:0] dt);
    dl = d;
    idx = i;
    wr = w;
    addr = a;
    dout = dt;
    @(posedge clk);
    #1;
  endtask

  task automatic startDownload(input logic [7:0] i);
    applyStimulus(1'b0, i, 1'b0, '0, '0);
    applyStimulus(1'b1, i, 1'b0, '0, '0);
    applyStimulus(1'b1, i, 1'b0, '0, '0);
  endtask

  task automatic sendImage(input int end_a, input bit rnd, input int skip);
    int r, off;
    bit inmap;
    for (int a = 0; a < end_a; a++) begin
      model_decode(a, r, off, inmap);
      if (inmap && a != skip) begin
        applyStimulus(1'b1, 8'd0, 1'b1, 25'(a), rnd ? 8'($urandom) : 8'(a));
      end
    end
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_we"}, 32'(we), 32'h0);
    checkOutput({tag, "_wr_addr"}, 32'(wr_addr), 32'h0);
    checkOutput({tag, "_wr_data"}, 32'(wr_data), 32'h0);
    checkOutput({tag, "_done"}, 32'(done), 32'h0);
    checkOutput({tag, "_err"}, 32'(err), 32'h0);
    checkOutput({tag, "_checksum"}, 32'(checksum), 32'h0);
    checkOutput({tag, "_core_rstn"}, 32'(core_rstn), 32'h0);
  endtask

  int t_done;
  int t_run;

  initial begin
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_en = 1'b1;
    checkResetValues("reset");
    rst_n = 1'b1;
    applyStimulus(1'b0, 8'd0, 1'b0, '0, '0);

    // Abort a load part-way with an asynchronous reset.
    $display("[TB] reset during load");
    startDownload(8'd0);
    sendImage('h3000, 1'b1, -1);
    #2;
    rst_n = 1'b0;
    dl = 1'b0;
    wr = 1'b0;
    #1;
    checkResetValues("midload_reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    applyStimulus(1'b0, 8'd0, 1'b0, '0, '0);

    // Complete image in address order, data = low address byte.
    $display("[TB] full image");
    startDownload(8'd0);
    sendImage('hA200, 1'b0, -1);
    applyStimulus(1'b0, 8'd0, 1'b0, '0, '0);
    t_done = -1;
    t_run = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done && t_done < 0) t_done = i;
      if (core_rstn && t_run < 0) t_run = i;
    end
    checkOutput("full_done", 32'(done), 32'h1);
    checkOutput("full_err", 32'(err), 32'h0);
    checkOutput("full_checksum", 32'(checksum), 32'h4150);
    checkOutput("full_core_rstn", 32'(core_rstn), 32'h1);
    checkOutput("hold_seen", 32'((t_done >= 0) && (t_run >= 0)), 32'h1);
    checkOutput("hold_delay", 32'(t_run - t_done), 32'(HOLD));

    // Foreign-index download while running must be invisible.
    $display("[TB] foreign index download");
    startDownload(8'd1);
    for (int i = 0; i < 64; i++) begin
      applyStimulus(1'b1, 8'd1, 1'b1, 25'($urandom_range(0, 'hA1FF)), 8'($urandom));
    end
    applyStimulus(1'b0, 8'd1, 1'b0, '0, '0);
    repeat (4) applyStimulus(1'b0, 8'd0, 1'b0, '0, '0);
    checkOutput("foreign_core_rstn", 32'(core_rstn), 32'h1);
    checkOutput("foreign_checksum", 32'(checksum), 32'h4150);
    checkOutput("foreign_done", 32'(done), 32'h1);

    // Single chr_h byte, then an out-of-map byte in the colour PROM page.
    $display("[TB] single byte and out-of-map byte");
    startDownload(8'd0);
    checkOutput("reload_core_rstn", 32'(core_rstn), 32'h0);
    applyStimulus(1'b1, 8'd0, 1'b1, 25'h09005, 8'h5A);
    checkOutput("chr_h_we", 32'(we), 32'h040);
    checkOutput("chr_h_addr", 32'(wr_addr), 32'h0005);
    checkOutput("chr_h_data", 32'(wr_data), 32'h5A);
    applyStimulus(1'b1, 8'd0, 1'b0, '0, '0);
    checkOutput("chr_h_pulse_end", 32'(we), 32'h0);
    applyStimulus(1'b1, 8'd0, 1'b1, 25'h0A060, 8'h33);
    checkOutput("oom_we", 32'(we), 32'h0);
    applyStimulus(1'b0, 8'd0, 1'b0, '0, '0);
    repeat (3) applyStimulus(1'b0, 8'd0, 1'b0, '0, '0);
    checkOutput("oom_err", 32'(err), 32'h1);
    checkOutput("oom_done", 32'(done), 32'h0);
    checkOutput("oom_checksum", 32'(checksum), 32'h005A);

    // Image short by the final decrypt byte, random data.
    $display("[TB] image missing last decrypt byte");
    startDownload(8'd0);
    sendImage('hA200, 1'b1, 'hA1FF);
    applyStimulus(1'b0, 8'd0, 1'b0, '0, '0);
    repeat (30) applyStimulus(1'b0, 8'd0, 1'b0, '0, '0);
    checkOutput("short_err", 32'(err), 32'h1);
    checkOutput("short_done", 32'(done), 32'h0);
    checkOutput("short_core_rstn", 32'(core_rstn), 32'h0);

    // Randomized traffic: stray strobes, mixed addresses, gaps, foreign indices.
    $display("[TB] randomized traffic");
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b0, 8'd0, 1'($urandom), 25'($urandom), 8'($urandom));
    end
    startDownload(8'd0);
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        applyStimulus(1'b1, 8'd0, 1'($urandom_range(0, 3) != 0), 25'($urandom), 8'($urandom));
      end else begin
        applyStimulus(1'b1, 8'd0, 1'($urandom_range(0, 3) != 0),
                      25'($urandom_range(0, 'hA1FF)), 8'($urandom));
      end
    end
    applyStimulus(1'b0, 8'd0, 1'b0, '0, '0);
    repeat (5) applyStimulus(1'b0, 8'd0, 1'b0, '0, '0);
    startDownload(8'($urandom_range(1, 255)));
    for (int i = 0; i < 50; i++) begin
      applyStimulus(1'b1, idx, 1'($urandom), 25'($urandom_range(0, 'hA1FF)), 8'($urandom));
    end
    applyStimulus(1'b0, 8'd0, 1'b0, '0, '0);
    repeat (5) applyStimulus(1'b0, 8'd0, 1'b0, '0, '0);

    check_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
